frame_transfer_fifo: RTL and testbench
======================================

Name: frame_transfer_fifo

Overview:
- Parametrised, buffered successor of the single-beat frame transfer link.
- Sits between a frame source (camera pipeline stage) and a frame destination (encoder/DMA).
- Stores beats of {macroblock type, pixel data, macroblock end} in a DEPTH-entry FIFO with ready/active backpressure on both sides.
- Adds per-macroblock length/type checking and an optional store-and-forward (packet) mode that releases only complete macroblocks.

Parameters:
- DATA_W, 24: pixel data width in bits (24 = RGB24).
- TYPE_W, 2: macroblock type field width.
- DEPTH, 512: FIFO entries; power of two, >= 2.
- MB_PIXELS, 256: beats per macroblock (16x16); range 1..65535.
- PACKET_MODE, 0: 0 = cut-through; 1 = store-and-forward per macroblock. PACKET_MODE=1 requires DEPTH >= MB_PIXELS.

Ports:
- ul1Clock  in  1  common clock; all logic on rising edge.
- ul1Reset_n  in  1  synchronous active-low reset.
- ul1SrcActive  in  1  source beat valid.
- uSrcMacroBlockType  in  TYPE_W  macroblock type of the beat.
- uSrcData  in  DATA_W  pixel data.
- ul1SrcMacroBlockEnd  in  1  last beat of the macroblock.
- ul1SrcReady  out  1  FIFO can accept a beat.
- ul1DestActive  out  1  output beat valid.
- uDestMacroBlockType  out  TYPE_W  head-entry type.
- uDestData  out  DATA_W  head-entry data.
- ul1DestMacroBlockEnd  out  1  head-entry end flag.
- ul1DestReady  in  1  destination accepts a beat.
- uFillLevel  out  $clog2(DEPTH+1)  stored entries.
- ul1ErrShortMb  out  1  sticky: end flag seen before MB_PIXELS beats.
- ul1ErrLongMb  out  1  sticky: MB_PIXELS beats with no end flag.
- ul1ErrTypeChange  out  1  sticky: type changed inside a macroblock.
- ul1ErrClear  in  1  clears the sticky error flags.

Behaviour:
- Reset values (ul1Reset_n=0 at a clock edge):
  - FIFO is flushed; pointers, fill level and macroblock counter go to 0.
  - ul1SrcReady=0, ul1DestActive=0, dest data/type/end=0, all error flags=0.
  - ul1SrcReady rises on the first edge after reset deasserts.
  - A reset mid-macroblock discards all stored data and any partial pixel count.
- Push: occurs when ul1SrcActive and ul1SrcReady are both 1 at the edge.
  - ul1SrcReady is registered and equals (fill level < DEPTH) for the next cycle.
  - Ready does not rise on a same-cycle pop while the FIFO is full; a full FIFO with a pop shows ready=1 on the next cycle.
- Pop: occurs when ul1DestActive and ul1DestReady are both 1.
  - Dest outputs are first-word-fall-through from the head entry and are stable while active=1 and ready=0.
- Latency: a beat pushed at edge N is presented with ul1DestActive=1 after edge N+1, when the FIFO was empty and cut-through mode applies.
- Fill level: uFillLevel = pushes - pops and updates at each edge. A simultaneous push and pop leaves it unchanged. Pointers wrap modulo DEPTH.
- Macroblock counter (store-and-forward):
  - Counts stored entries whose end flag is 1.
  - Increments on a push with end=1 and decrements on a pop with end=1; both at once leaves it unchanged.
  - PACKET_MODE=1: ul1DestActive = not empty AND counter != 0.
  - PACKET_MODE=0: ul1DestActive = not empty.
- Input checker: a pixel counter (16-bit) and a latched type track each pushed beat; the checker acts on pushes only.
  - First beat of a macroblock latches its type.
  - Subsequent beats with a different type set ul1ErrTypeChange.
  - End flag on beat k < MB_PIXELS sets ul1ErrShortMb; the counter returns to 0.
  - Beat MB_PIXELS without an end flag sets ul1ErrLongMb; the counter returns to 0 and the next beat starts a new macroblock.
  - Correct end on beat MB_PIXELS returns the counter to 0 with no error.
- Errors: erroneous beats are still stored and forwarded unchanged.
  - Error flags are sticky until ul1ErrClear=1 at an edge.
  - If an error event and ul1ErrClear=1 occur at the same edge, the flag is set (the event wins).
- Packet-mode deadlock: a macroblock longer than DEPTH can never be released. ul1ErrLongMb flags it; recovery is by reset.

Test Plan:
- Cut-through streaming, MB_PIXELS=4, DEPTH=8, dest ready held 1: push 3 macroblocks with data 0..11 and end on beats 3/7/11 -> output data 0..11 in order, ends at the same positions, first output one cycle after the first push, no errors, uFillLevel <= 1.
- Full/backpressure: dest ready=0, push 10 beats into DEPTH=8 -> ul1SrcReady=0 after the 8th push, uFillLevel=8; release dest ready -> all 8 beats out in order, SrcReady=1 the cycle after the first pop; remaining 2 beats then accepted.
- Store-and-forward, PACKET_MODE=1, MB_PIXELS=4: push beats 0..2 and stall -> ul1DestActive stays 0; push beat 3 with end -> DestActive=1 the next cycle and beats 0..3 pop in order.
- Checker: end on beat 2 of MB_PIXELS=4 -> ul1ErrShortMb=1; 4 beats without end -> ul1ErrLongMb=1; type 1 then 2 within one macroblock -> ul1ErrTypeChange=1; pulse ul1ErrClear -> all three flags 0 the next cycle.
- Simultaneous push/pop at fill level 5 for 20 cycles -> uFillLevel stays 5, data order preserved across pointer wrap.
- Reset mid-macroblock with fill level 6 -> next cycle uFillLevel=0, DestActive=0, SrcReady=0, then 1; a new macroblock of 4 beats passes with no error.

Source files
------------

// File: rtl/frame_transfer_fifo.sv
// frame_transfer_fifo
// Buffered frame link between a camera pipeline stage and an encoder/DMA.
// Beats of {macroblock type, pixel data, macroblock end} are stored in a
// DEPTH-entry FIFO with ready/active backpressure on both sides. Pushed
// beats are also checked against the expected macroblock length and a
// constant type, with sticky error flags.
// PACKET_MODE=1 holds output back until a complete macroblock is stored.
// In that mode DEPTH must be at least MB_PIXELS, otherwise a full-length
// macroblock never completes inside the FIFO and only reset recovers.
// The destination side is a registered view of the head entry. It only
// shows entries stored before the current edge. This gives a beat one
// cycle of storage latency and keeps every output a flop.
module frame_transfer_fifo #(
    parameter int DATA_W      = 24,
    parameter int TYPE_W      = 2,
    parameter int DEPTH       = 512,
    parameter int MB_PIXELS   = 256,
    parameter int PACKET_MODE = 0
) (
    input  logic                       ul1Clock,
    input  logic                       ul1Reset_n,
    input  logic                       ul1SrcActive,
    input  logic [TYPE_W-1:0]          uSrcMacroBlockType,
    input  logic [DATA_W-1:0]          uSrcData,
    input  logic                       ul1SrcMacroBlockEnd,
    output logic                       ul1SrcReady,
    output logic                       ul1DestActive,
    output logic [TYPE_W-1:0]          uDestMacroBlockType,
    output logic [DATA_W-1:0]          uDestData,
    output logic                       ul1DestMacroBlockEnd,
    input  logic                       ul1DestReady,
    output logic [$clog2(DEPTH+1)-1:0] uFillLevel,
    output logic                       ul1ErrShortMb,
    output logic                       ul1ErrLongMb,
    output logic                       ul1ErrTypeChange,
    input  logic                       ul1ErrClear
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = TYPE_W + DATA_W + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [15:0]   MB_PIX_C = 16'(MB_PIXELS);

    // Storage is not reset: pointers and count define which entries are live.
    logic [EW-1:0]     mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     mb_cnt_q, mb_cnt_d;
    logic              src_ready_q, src_ready_d;
    logic              dest_active_q, dest_active_d;
    logic [TYPE_W-1:0] dest_type_q, dest_type_d;
    logic [DATA_W-1:0] dest_data_q, dest_data_d;
    logic              dest_end_q, dest_end_d;
    logic [15:0]       pix_cnt_q, pix_cnt_d;
    logic [TYPE_W-1:0] type_lat_q, type_lat_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q, err_long_d;
    logic              err_type_q, err_type_d;

    logic              push_s, pop_s, push_end_s, pop_end_s;
    logic [CW-1:0]     avail_s, avail_mb_s;
    logic [EW-1:0]     head_s;
    logic [15:0]       beat_num_s;
    logic              evt_short_s, evt_long_s, evt_type_s;

    // Next-state logic for pointers, counters, output view and input checker.
    always_comb begin
        push_s      = ul1SrcActive && src_ready_q;
        pop_s       = dest_active_q && ul1DestReady;
        push_end_s  = push_s && ul1SrcMacroBlockEnd;
        pop_end_s   = pop_s && dest_end_q;

        wr_ptr_d    = wr_ptr_q + AW'(push_s);
        rd_ptr_d    = rd_ptr_q + AW'(pop_s);
        count_d     = count_q + CW'(push_s) - CW'(pop_s);
        mb_cnt_d    = mb_cnt_q + CW'(push_end_s) - CW'(pop_end_s);
        src_ready_d = (count_d < DEPTH_C);

        // Entries (and complete macroblocks) that existed before this edge
        // and survive its pop; a beat written at this edge is not yet visible.
        avail_s    = count_q - CW'(pop_s);
        avail_mb_s = mb_cnt_q - CW'(pop_end_s);
        if (PACKET_MODE != 0) begin
            dest_active_d = (avail_s != {CW{1'b0}}) && (avail_mb_s != {CW{1'b0}});
        end else begin
            dest_active_d = (avail_s != {CW{1'b0}});
        end

        head_s = mem_q[rd_ptr_d];
        if (dest_active_d) begin
            {dest_type_d, dest_data_d, dest_end_d} = head_s;
        end else begin
            {dest_type_d, dest_data_d, dest_end_d} = {EW{1'b0}};
        end

        // Macroblock checker, driven by accepted beats only.
        beat_num_s  = pix_cnt_q + 16'd1;
        pix_cnt_d   = pix_cnt_q;
        type_lat_d  = type_lat_q;
        evt_short_s = 1'b0;
        evt_long_s  = 1'b0;
        evt_type_s  = 1'b0;
        if (push_s) begin
            if (pix_cnt_q == 16'd0) begin
                type_lat_d = uSrcMacroBlockType;
            end else if (uSrcMacroBlockType != type_lat_q) begin
                evt_type_s = 1'b1;
            end else begin
                evt_type_s = 1'b0;
            end

            if (ul1SrcMacroBlockEnd) begin
                pix_cnt_d   = 16'd0;
                evt_short_s = (beat_num_s < MB_PIX_C);
            end else if (beat_num_s == MB_PIX_C) begin
                pix_cnt_d  = 16'd0;
                evt_long_s = 1'b1;
            end else begin
                pix_cnt_d = beat_num_s;
            end
        end else begin
            pix_cnt_d = pix_cnt_q;
        end

        // Sticky flags; a new event at the clearing edge keeps the flag set.
        if (ul1ErrClear) begin
            err_short_d = evt_short_s;
            err_long_d  = evt_long_s;
            err_type_d  = evt_type_s;
        end else begin
            err_short_d = err_short_q | evt_short_s;
            err_long_d  = err_long_q  | evt_long_s;
            err_type_d  = err_type_q  | evt_type_s;
        end
    end

    // Beat storage write on every accepted push.
    always_ff @(posedge ul1Clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {uSrcMacroBlockType, uSrcData, ul1SrcMacroBlockEnd};
        end
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge ul1Clock) begin
        if (!ul1Reset_n) begin
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {CW{1'b0}};
            mb_cnt_q      <= {CW{1'b0}};
            src_ready_q   <= 1'b0;
            dest_active_q <= 1'b0;
            dest_type_q   <= {TYPE_W{1'b0}};
            dest_data_q   <= {DATA_W{1'b0}};
            dest_end_q    <= 1'b0;
            pix_cnt_q     <= 16'd0;
            type_lat_q    <= {TYPE_W{1'b0}};
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_type_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mb_cnt_q      <= mb_cnt_d;
            src_ready_q   <= src_ready_d;
            dest_active_q <= dest_active_d;
            dest_type_q   <= dest_type_d;
            dest_data_q   <= dest_data_d;
            dest_end_q    <= dest_end_d;
            pix_cnt_q     <= pix_cnt_d;
            type_lat_q    <= type_lat_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_type_q    <= err_type_d;
        end
    end

    assign ul1SrcReady          = src_ready_q;
    assign ul1DestActive        = dest_active_q;
    assign uDestMacroBlockType  = dest_type_q;
    assign uDestData            = dest_data_q;
    assign ul1DestMacroBlockEnd = dest_end_q;
    assign uFillLevel           = count_q;
    assign ul1ErrShortMb        = err_short_q;
    assign ul1ErrLongMb         = err_long_q;
    assign ul1ErrTypeChange     = err_type_q;

endmodule

// File: tb/tb_frame_transfer_fifo.sv
// Directed bench for frame_transfer_fifo with DEPTH=8, MB_PIXELS=4.
// One cut-through and one store-and-forward instance share all inputs.
module tb_frame_transfer_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        src_active;
    logic [1:0]  src_type;
    logic [23:0] src_data;
    logic        src_end;
    logic        dest_ready;
    logic        err_clear;

    logic        ct_src_ready, ct_dest_active, ct_dest_end;
    logic [1:0]  ct_dest_type;
    logic [23:0] ct_dest_data;
    logic [3:0]  ct_fill;
    logic        ct_err_short, ct_err_long, ct_err_type;

    logic        pk_src_ready, pk_dest_active, pk_dest_end;
    logic [1:0]  pk_dest_type;
    logic [23:0] pk_dest_data;
    logic [3:0]  pk_fill;
    logic        pk_err_short, pk_err_long, pk_err_type;

    int n_cmp = 0;
    int n_err = 0;
    int in_idx, out_idx, base;

    always #5 clk = ~clk;

    frame_transfer_fifo #(.DATA_W(24), .TYPE_W(2), .DEPTH(8), .MB_PIXELS(4), .PACKET_MODE(0)) dut_ct (
        .ul1Clock(clk), .ul1Reset_n(rst_n), .ul1SrcActive(src_active),
        .uSrcMacroBlockType(src_type), .uSrcData(src_data), .ul1SrcMacroBlockEnd(src_end),
        .ul1SrcReady(ct_src_ready), .ul1DestActive(ct_dest_active),
        .uDestMacroBlockType(ct_dest_type), .uDestData(ct_dest_data),
        .ul1DestMacroBlockEnd(ct_dest_end), .ul1DestReady(dest_ready), .uFillLevel(ct_fill),
        .ul1ErrShortMb(ct_err_short), .ul1ErrLongMb(ct_err_long),
        .ul1ErrTypeChange(ct_err_type), .ul1ErrClear(err_clear)
    );

    frame_transfer_fifo #(.DATA_W(24), .TYPE_W(2), .DEPTH(8), .MB_PIXELS(4), .PACKET_MODE(1)) dut_pk (
        .ul1Clock(clk), .ul1Reset_n(rst_n), .ul1SrcActive(src_active),
        .uSrcMacroBlockType(src_type), .uSrcData(src_data), .ul1SrcMacroBlockEnd(src_end),
        .ul1SrcReady(pk_src_ready), .ul1DestActive(pk_dest_active),
        .uDestMacroBlockType(pk_dest_type), .uDestData(pk_dest_data),
        .ul1DestMacroBlockEnd(pk_dest_end), .ul1DestReady(dest_ready), .uFillLevel(pk_fill),
        .ul1ErrShortMb(pk_err_short), .ul1ErrLongMb(pk_err_long),
        .ul1ErrTypeChange(pk_err_type), .ul1ErrClear(err_clear)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_errs(input string tag, input logic s, input logic l, input logic t);
        check_eq({tag, "_short"}, ct_err_short, s);
        check_eq({tag, "_long"},  ct_err_long,  l);
        check_eq({tag, "_type"},  ct_err_type,  t);
    endtask

    task automatic do_reset();
        src_active = 1'b0; src_type = 2'd0; src_data = 24'd0; src_end = 1'b0;
        dest_ready = 1'b0; err_clear = 1'b0;
        rst_n = 1'b0;
        tick();
        check_eq("rst_fill",   ct_fill, 4'd0);
        check_eq("rst_ready",  ct_src_ready, 1'b0);
        check_eq("rst_active", ct_dest_active, 1'b0);
        check_eq("rst_data",   ct_dest_data, 24'd0);
        check_eq("rst_end",    ct_dest_end, 1'b0);
        check_eq("rst_pk_fill", pk_fill, 4'd0);
        check_errs("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_ready_rise", ct_src_ready, 1'b1);
    endtask

    task automatic drive_beat(input int idx);
        src_active = 1'b1;
        src_type   = 2'd0;
        src_data   = 24'(base + idx);
        src_end    = ((idx % 4) == 3);
    endtask

    // Records the beat that the coming edge pops from the cut-through DUT.
    task automatic sample_ct();
        if (ct_dest_active && dest_ready) begin
            check_eq("out_data", ct_dest_data, 32'(base + out_idx));
            check_eq("out_end",  ct_dest_end, ((out_idx % 4) == 3));
            check_eq("out_type", ct_dest_type, 2'd0);
            out_idx++;
        end
    endtask

    task automatic push_one(input logic [1:0] t, input logic [23:0] d, input logic e);
        src_active = 1'b1; src_type = t; src_data = d; src_end = e;
        for (int w = 0; w < 50 && !ct_src_ready; w++) tick();
        check_eq("push_ready", ct_src_ready, 1'b1);
        tick();
        src_active = 1'b0; src_end = 1'b0;
    endtask

    task automatic run_stream(input int n, input bit gap, input int max_cyc, input bit chk_lat);
        bit will_push;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            if (in_idx >= n && out_idx >= n) break;
            if (in_idx < n && (!gap || (cyc % 2) == 0)) drive_beat(in_idx);
            else begin src_active = 1'b0; src_end = 1'b0; end
            will_push = src_active && ct_src_ready;
            sample_ct();
            tick();
            if (will_push) in_idx++;
            if (gap) check_eq("fill_le1", (ct_fill <= 4'd1), 1'b1);
            if (chk_lat && cyc == 0) check_eq("lat_not_yet", ct_dest_active, 1'b0);
            if (chk_lat && cyc == 1) check_eq("lat_active", ct_dest_active, 1'b1);
        end
        src_active = 1'b0; src_end = 1'b0;
        check_eq("stream_count", out_idx, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Cut-through streaming with a gap between beats.
        do_reset();
        dest_ready = 1'b1; base = 0; in_idx = 0; out_idx = 0;
        run_stream(12, 1'b1, 60, 1'b1);
        check_errs("ct", 1'b0, 1'b0, 1'b0);

        // Fill to full with destination stalled, then release.
        do_reset();
        base = 100; in_idx = 0; out_idx = 0;
        for (int i = 0; i < 8; i++) begin drive_beat(i); tick(); end
        in_idx = 8;
        check_eq("full_ready", ct_src_ready, 1'b0);
        check_eq("full_fill",  ct_fill, 4'd8);
        drive_beat(8);
        tick();
        check_eq("full_hold_fill", ct_fill, 4'd8);
        check_eq("full_hold_data", ct_dest_data, 24'd100);
        dest_ready = 1'b1;
        sample_ct();
        tick();
        check_eq("pop_ready", ct_src_ready, 1'b1);
        check_eq("pop_fill",  ct_fill, 4'd7);
        run_stream(10, 1'b0, 60, 1'b0);

        // Store-and-forward release only after the macroblock end.
        do_reset();
        dest_ready = 1'b1; base = 300;
        for (int i = 0; i < 3; i++) begin drive_beat(i); tick(); end
        src_active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("pk_stall", pk_dest_active, 1'b0);
        end
        drive_beat(3);
        tick();
        src_active = 1'b0; src_end = 1'b0;
        tick();
        check_eq("pk_release", pk_dest_active, 1'b1);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (pk_dest_active && dest_ready) begin
                check_eq("pk_data", pk_dest_data, 32'(300 + k));
                check_eq("pk_end",  pk_dest_end, (k == 3));
                k++;
            end
            tick();
        end
        check_eq("pk_count", k, 4);
        check_eq("pk_fill_empty", pk_fill, 4'd0);

        // Macroblock checker.
        do_reset();
        dest_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_one(2'd0, 24'(i), (i == 3));
        check_errs("good", 1'b0, 1'b0, 1'b0);
        push_one(2'd0, 24'd10, 1'b0);
        push_one(2'd0, 24'd11, 1'b1);
        check_errs("short", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_one(2'd0, 24'(20 + i), 1'b0);
        check_errs("long", 1'b1, 1'b1, 1'b0);
        push_one(2'd1, 24'd30, 1'b0);
        check_errs("type_pre", 1'b1, 1'b1, 1'b0);
        push_one(2'd2, 24'd31, 1'b0);
        push_one(2'd1, 24'd32, 1'b0);
        push_one(2'd1, 24'd33, 1'b1);
        check_errs("type", 1'b1, 1'b1, 1'b1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check_errs("clear", 1'b0, 1'b0, 1'b0);
        push_one(2'd1, 24'd40, 1'b0);
        err_clear = 1'b1;
        push_one(2'd2, 24'd41, 1'b0);
        err_clear = 1'b0;
        check_errs("event_wins", 1'b0, 1'b0, 1'b1);

        // Simultaneous push/pop at fill level 5 across pointer wrap.
        do_reset();
        base = 200; in_idx = 0; out_idx = 0;
        for (int i = 0; i < 5; i++) begin drive_beat(i); tick(); end
        in_idx = 5;
        check_eq("wrap_fill_start", ct_fill, 4'd5);
        dest_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive_beat(in_idx);
            sample_ct();
            tick();
            in_idx++;
            check_eq("wrap_fill", ct_fill, 4'd5);
        end
        src_active = 1'b0; src_end = 1'b0;
        run_stream(25, 1'b0, 40, 1'b0);
        check_eq("wrap_empty", ct_fill, 4'd0);

        // Reset in the middle of a macroblock.
        do_reset();
        for (int i = 0; i < 6; i++) push_one(2'd0, 24'(50 + i), (i == 3));
        check_eq("mid_fill", ct_fill, 4'd6);
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_fill",   ct_fill, 4'd0);
        check_eq("mid_rst_active", ct_dest_active, 1'b0);
        check_eq("mid_rst_ready",  ct_src_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        check_eq("mid_ready_rise", ct_src_ready, 1'b1);
        dest_ready = 1'b1; base = 400; in_idx = 0; out_idx = 0;
        run_stream(4, 1'b0, 30, 1'b0);
        check_errs("mid_new_mb", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
